// File: rtl/dvi_pattern_pkg.sv
// -----------------------------------------------------------------------------
// dvi_pattern_pkg
// Shared definitions for the DVI test-pattern generator.
//   PAT_*      : pattern select codes carried on the 3-bit mode input
//   rgb1_t     : one bit per colour channel, expanded to full width by the user
//   bar_color  : colour-bar lookup, bar 0 at the left edge of the screen
// -----------------------------------------------------------------------------
package dvi_pattern_pkg;

    localparam logic [2:0] PAT_SOLID    = 3'd0;
    localparam logic [2:0] PAT_BORDER   = 3'd1;
    localparam logic [2:0] PAT_BARS     = 3'd2;
    localparam logic [2:0] PAT_CHECKER  = 3'd3;
    localparam logic [2:0] PAT_GRADIENT = 3'd4;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb1_t;

    // White, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb1_t bar_color(input logic [2:0] idx);
        rgb1_t c;
        case (idx)
            3'd0:    c = '{r: 1'b1, g: 1'b1, b: 1'b1};
            3'd1:    c = '{r: 1'b1, g: 1'b1, b: 1'b0};
            3'd2:    c = '{r: 1'b0, g: 1'b1, b: 1'b1};
            3'd3:    c = '{r: 1'b0, g: 1'b1, b: 1'b0};
            3'd4:    c = '{r: 1'b1, g: 1'b0, b: 1'b1};
            3'd5:    c = '{r: 1'b1, g: 1'b0, b: 1'b0};
            3'd6:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
            default: c = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_pattern_if.sv
// -----------------------------------------------------------------------------
// dvi_pattern_if
// Pixel bus between the pattern generator and the DVI pmod output registers.
//   r, g, b : colour channels, COLOR_W bits each
//   hs, vs  : syncs, active-high, aligned with the colour channels
//   de      : data enable, aligned with the colour channels
// Modports: master drives the bus (generator), slave consumes it.
// -----------------------------------------------------------------------------
interface dvi_pattern_if #(
    parameter int COLOR_W = 4
);
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               hs;
    logic               vs;
    logic               de;

    modport master (output r, g, b, hs, vs, de);
    modport slave  (input  r, g, b, hs, vs, de);
endinterface

// File: rtl/dvi_pos_tracker.sv
// -----------------------------------------------------------------------------
// dvi_pos_tracker
// Derives the active-area pixel position from data_en so that the pattern is
// anchored to the visible picture rather than to the sync pulses.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   vsync      : frame marker; its rising edge clears y, bumps frame, latches mode
//   data_en    : active-video enable
//   mode       : requested pattern, taken only at a vsync rise
//   x, y       : position of the pixel currently on data_en (saturating)
//   frame      : free-running frame counter, wraps
//   mode_q     : pattern in effect for the current frame
// -----------------------------------------------------------------------------
module dvi_pos_tracker #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int POS_W    = 12,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               data_en,
    input  logic [2:0]         mode,
    output logic [POS_W-1:0]   x,
    output logic [POS_W-1:0]   y,
    output logic [FRAME_W-1:0] frame,
    output logic [2:0]         mode_q
);

    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - 1);

    logic de_q;
    logic vs_q;
    logic vs_rise;
    logic de_fall;

    assign vs_rise = vsync & ~vs_q;
    assign de_fall = de_q & ~data_en;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of de_q/vs_q/x/y regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q   <= 1'b0;
            vs_q   <= 1'b0;
            x      <= '0;
            y      <= '0;
            frame  <= '0;
            mode_q <= '0;
        end else begin
            de_q <= data_en;
            vs_q <= vsync;

            // x holds the index of the pixel being presented this cycle, so it
            // is already 0 on the first data_en cycle of a line.
            if (!data_en)
                x <= '0;
            else if (x != X_MAX)
                x <= x + POS_W'(1);

            // A vsync rise coinciding with the last de fall must leave y at 0.
            if (vs_rise)
                y <= '0;
            else if (de_fall && (y != Y_MAX))
                y <= y + POS_W'(1);

            if (vs_rise) begin
                frame  <= frame + FRAME_W'(1);
                mode_q <= mode;
            end
        end
    end

endmodule

// File: rtl/dvi_pattern_gen.sv
// -----------------------------------------------------------------------------
// dvi_pattern_gen
// DVI test-pattern generator placed between video_timing and the 12-bit pmod
// output registers. Two-cycle latency from every input to every output:
// stage 1 registers the pattern colour, stage 2 registers the output and
// blanks it whenever the delayed data enable is low.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   hsync, vsync    : syncs from video_timing (active-high)
//   data_en         : active-video enable from video_timing
//   mode            : pattern select (0 solid, 1 border, 2 bars, 3 checker,
//                     4 gradient, 5-7 black), sampled at frame start
//   vid             : pixel bus out (master modport), hs/vs/de aligned to RGB
//   frame           : frame counter
// Build option: define PATTERN_ANIM_EN to make the border colour follow the
// frame counter and to scroll the checkerboard one pixel per frame.
// -----------------------------------------------------------------------------
module dvi_pattern_gen
    import dvi_pattern_pkg::*;
#(
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int BORDER   = 64,
    parameter int POS_W    = 12,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               data_en,
    input  logic [2:0]         mode,
    dvi_pattern_if.master      vid,
    output logic [FRAME_W-1:0] frame
);

    localparam logic [COLOR_W-1:0] M     = '1;
    localparam int                 BAR_W = H_ACTIVE / 8;
    // Gradient scaling: a power-of-two width is stretched to the full counter
    // range by a constant shift; otherwise the raw top bits of x are used.
    localparam bit                 H_POW2  = ((H_ACTIVE & (H_ACTIVE - 1)) == 0);
    localparam int                 H_SHIFT = (POS_W > $clog2(H_ACTIVE)) ?
                                             (POS_W - $clog2(H_ACTIVE)) : 0;

    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
    logic [2:0]         mode_q;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;
    logic [COLOR_W-1:0] s1_r, s1_g, s1_b;
    logic               hs_d1, vs_d1, de_d1;
    logic [2:0]         bar_idx;
    rgb1_t              bar;
    logic               in_border;
    logic               chk_bit;
    logic [COLOR_W-1:0] border_col;
    logic [COLOR_W-1:0] grad;

    dvi_pos_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .POS_W    (POS_W),
        .FRAME_W  (FRAME_W)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .vsync   (vsync),
        .data_en (data_en),
        .mode    (mode),
        .x       (x),
        .y       (y),
        .frame   (frame),
        .mode_q  (mode_q)
    );

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        bar_idx = 3'd0;

        // Bar index by constant compares against the bar edges.
        for (int k = 1; k < 8; k++) begin
            if (x >= POS_W'(k * BAR_W))
                bar_idx = 3'(k);
        end
        bar = bar_color(bar_idx);

        in_border = (y < POS_W'(BORDER)) || (y >= POS_W'(V_ACTIVE - BORDER)) ||
                    (x < POS_W'(BORDER)) || (x >= POS_W'(H_ACTIVE - BORDER));

`ifdef PATTERN_ANIM_EN
        border_col = frame[COLOR_W-1:0];
        chk_bit    = 1'((x + POS_W'(frame)) >> 5) ^ y[5];
`else
        border_col = M;
        chk_bit    = x[5] ^ y[5];
`endif

        grad = COLOR_W'((H_POW2 ? (x << H_SHIFT) : x) >> (POS_W - COLOR_W));

        case (mode_q)
            PAT_SOLID: begin
                pat_r = M;
            end
            PAT_BORDER: begin
                pat_r = in_border ? border_col : M;
                pat_g = in_border ? border_col : '0;
                pat_b = in_border ? border_col : '0;
            end
            PAT_BARS: begin
                pat_r = {COLOR_W{bar.r}};
                pat_g = {COLOR_W{bar.g}};
                pat_b = {COLOR_W{bar.b}};
            end
            PAT_CHECKER: begin
                pat_r = {COLOR_W{chk_bit}};
                pat_g = {COLOR_W{chk_bit}};
                pat_b = {COLOR_W{chk_bit}};
            end
            PAT_GRADIENT: begin
                pat_r = grad;
                pat_g = grad;
                pat_b = grad;
            end
            default: ;
        endcase
    end

    // NOTE: only control and datapath flops live here; all of them are
    // cleared by reset so the pmod sees black with syncs low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
            de_d1  <= 1'b0;
            vid.r  <= '0;
            vid.g  <= '0;
            vid.b  <= '0;
            vid.hs <= 1'b0;
            vid.vs <= 1'b0;
            vid.de <= 1'b0;
        end else begin
            s1_r   <= pat_r;
            s1_g   <= pat_g;
            s1_b   <= pat_b;
            hs_d1  <= hsync;
            vs_d1  <= vsync;
            de_d1  <= data_en;
            vid.r  <= de_d1 ? s1_r : '0;
            vid.g  <= de_d1 ? s1_g : '0;
            vid.b  <= de_d1 ? s1_b : '0;
            vid.hs <= hs_d1;
            vid.vs <= vs_d1;
            vid.de <= de_d1;
        end
    end

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_dvi_pattern_gen
// Directed bench for dvi_pattern_gen with default 1280x720 parameters.
// Lines are driven as bursts of data_en; short one-pixel lines are used to
// step y quickly. A negedge monitor stores each output line's pixels so a
// given x can be inspected after the line finishes.
// Honours PATTERN_ANIM_EN for the animated border/checker expectations.
// -----------------------------------------------------------------------------
module tb_dvi_pattern_gen;

    localparam int          CW     = 4;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] BLACK  = 12'h000;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       hsync   = 1'b0;
    logic       vsync   = 1'b0;
    logic       data_en = 1'b0;
    logic [2:0] mode    = 3'd0;
    logic [7:0] frame;

    dvi_pattern_if #(.COLOR_W(CW)) vid_if ();

    dvi_pattern_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hsync   (hsync),
        .vsync   (vsync),
        .data_en (data_en),
        .mode    (mode),
        .vid     (vid_if),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_pass    = 0;
    int frame_exp = 0;

    logic [11:0] line_buf [0:1399];
    int          pix_cnt = 0;

    always @(negedge clk) begin
        if (vid_if.de) begin
            if (pix_cnt < 1400)
                line_buf[pix_cnt] <= {vid_if.r, vid_if.g, vid_if.b};
            pix_cnt <= pix_cnt + 1;
        end else begin
            pix_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        step(2);
        vsync = 1'b0;
        step(2);
        frame_exp = (frame_exp + 1) % 256;
    endtask

    task automatic line(input int len);
        data_en = 1'b1;
        step(len);
        data_en = 1'b0;
        step(3);
    endtask

    task automatic skip(input int n);
        repeat (n) begin
            data_en = 1'b1;
            step(1);
            data_en = 1'b0;
            step(1);
        end
    endtask

    function automatic logic [11:0] rgb_now();
        return {vid_if.r, vid_if.g, vid_if.b};
    endfunction

    function automatic logic [11:0] border_exp();
`ifdef PATTERN_ANIM_EN
        logic [3:0] f = 4'(frame_exp);
        return {f, f, f};
`else
        return WHITE;
`endif
    endfunction

    // Checker colour on line y=0.
    function automatic logic [11:0] chk_exp(input int px);
`ifdef PATTERN_ANIM_EN
        int sx = px + frame_exp;
`else
        int sx = px;
`endif
        return ((sx >> 5) & 1) != 0 ? WHITE : BLACK;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with every input active: outputs must stay at zero.
        data_en = 1'b1;
        hsync   = 1'b1;
        vsync   = 1'b1;
        step(3);
        check("rst_rgb", 32'(rgb_now()), 0);
        check("rst_de", 32'(vid_if.de), 0);
        check("rst_hs", 32'(vid_if.hs), 0);
        check("rst_vs", 32'(vid_if.vs), 0);
        check("rst_frame", 32'(frame), 0);
        data_en = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        rst_n   = 1'b1;
        step(2);

        // vsync delay line and first frame count.
        vsync = 1'b1;
        step(1);
        check("vs_lat1", 32'(vid_if.vs), 0);
        step(1);
        check("vs_lat2", 32'(vid_if.vs), 1);
        vsync = 1'b0;
        step(2);
        check("vs_low", 32'(vid_if.vs), 0);
        frame_exp = 1;
        check("frame_1", 32'(frame), 1);

        // Mode 0 first pixel latency, hsync alignment.
        hsync   = 1'b1;
        data_en = 1'b1;
        step(1);
        check("de_lat1", 32'(vid_if.de), 0);
        check("hs_lat1", 32'(vid_if.hs), 0);
        hsync = 1'b0;
        step(1);
        check("de_lat2", 32'(vid_if.de), 1);
        check("hs_lat2", 32'(vid_if.hs), 1);
        check("solid_rgb", 32'(rgb_now()), 32'(RED));
        step(1);
        check("hs_fall", 32'(vid_if.hs), 0);
        step(5);

        // Asynchronous reset in the middle of an active line.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rgb", 32'(rgb_now()), 0);
        check("midrst_de", 32'(vid_if.de), 0);
        check("midrst_frame", 32'(frame), 0);
        frame_exp = 0;
        step(1);
        rst_n = 1'b1;
        step(1);
        check("post_rst_de1", 32'(vid_if.de), 0);
        step(1);
        check("post_rst_de2", 32'(vid_if.de), 1);
        check("post_rst_rgb", 32'(rgb_now()), 32'(RED));
        data_en = 1'b0;
        step(3);

        // Border pattern.
        mode = 3'd1;
        vsync_pulse();
        skip(63);
        line(101);                                  // y=63
        check("border_100_63", 32'(line_buf[100]), 32'(border_exp()));
        line(65);                                   // y=64
        check("inner_64_64", 32'(line_buf[64]), 32'(RED));
        skip(35);
        line(1217);                                 // y=100
        check("border_63_100", 32'(line_buf[63]), 32'(border_exp()));
        check("inner_64_100", 32'(line_buf[64]), 32'(RED));
        check("border_1216_100", 32'(line_buf[1216]), 32'(border_exp()));
        skip(554);
        line(1216);                                 // y=655
        check("inner_1215_655", 32'(line_buf[1215]), 32'(RED));
        line(101);                                  // y=656
        check("border_100_656", 32'(line_buf[100]), 32'(border_exp()));

        // Colour bars on line y=300.
        mode = 3'd2;
        vsync_pulse();
        skip(300);
        line(1121);
        check("bar_x0", 32'(line_buf[0]), 32'(WHITE));
        check("bar_x159", 32'(line_buf[159]), 32'(WHITE));
        check("bar_x160", 32'(line_buf[160]), 32'(YELLOW));
        check("bar_x1119", 32'(line_buf[1119]), 32'(BLUE));
        check("bar_x1120", 32'(line_buf[1120]), 32'(BLACK));

        // Mode change mid-frame only takes effect after the next vsync.
        mode = 3'd0;
        vsync_pulse();
        data_en = 1'b1;
        step(10);
        mode = 3'd3;
        step(23);
        data_en = 1'b0;
        step(3);
        check("switch_same_x0", 32'(line_buf[0]), 32'(RED));
        check("switch_same_x32", 32'(line_buf[32]), 32'(RED));
        vsync_pulse();
        line(33);
        check("switch_next_x0", 32'(line_buf[0]), 32'(chk_exp(0)));
        check("switch_next_x32", 32'(line_buf[32]), 32'(chk_exp(32)));

        // Reserved mode is black but still enabled.
        mode = 3'd5;
        vsync_pulse();
        line(10);
        check("reserved_x5", 32'(line_buf[5]), 32'(BLACK));

        // Gradient, including de held past the active width.
        mode = 3'd4;
        vsync_pulse();
        line(1400);
        check("grad_x0", 32'(line_buf[0]), 0);
        check("grad_x255", 32'(line_buf[255]), 0);
        check("grad_x256", 32'(line_buf[256]), 32'(12'h111));
        check("grad_x1279", 32'(line_buf[1279]), 32'(12'h444));
        check("grad_sat_x1399", 32'(line_buf[1399]), 32'(12'h444));

        // Frame counter run-up and wrap; checker (0,0) at frame 32.
        mode = 3'd3;
        while (frame_exp != 32)
            vsync_pulse();
        line(1);
        check("frame_32", 32'(frame), 32);
        check("chk_f32_x0", 32'(line_buf[0]), 32'(chk_exp(0)));
        while (frame_exp != 255)
            vsync_pulse();
        check("frame_255", 32'(frame), 255);
        vsync_pulse();
        check("frame_wrap", 32'(frame), 0);
        repeat (44)
            vsync_pulse();
        check("frame_after_wrap", 32'(frame), 44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
